ctr_mode_sched: RTL and testbench

- Scheduler that shares one 4-bit mod-10 load/shift/count counter between three requesters: a load client, a shift client and a count client.
- Each client raises a request with an operand. The block grants clients round-robin and drives the counter's load/shift/count/in controls.
- The counter registers its J/K inputs one cycle before its Q updates. The block therefore spaces control pulses so that every step sees the updated Q.
- When the operation completes, the block returns the final counter value with a one-cycle ack. It sits between the filter-bank control logic and the counter.

---
 rtl/ctr_mode_sched.sv | 155 +++++++++++++++
 tb/tb_ctr_mode_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_mode_sched.sv
// ctr_mode_sched
// Shares one 4-bit mod-10 load/shift/count counter between three clients
// (load, shift, count). Requests are granted round-robin while idle. The
// granted operation is played out as control pulses separated by GAP idle
// cycles, because the counter registers J/K one cycle before Q moves. The
// final counter value is returned with a one-cycle ack.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   load_req/load_data/load_ack load client (data = value to load)
//   shift_req/shift_len/shift_ack   shift client (len = rotate-left steps)
//   count_req/count_len/count_ack   count client (len = mod-10 increments)
//   result                      counter value at the last ack, held until the next ack
//   busy                        high whenever the scheduler is not idle
//   ctr_load/ctr_shift/ctr_count/ctr_in   controls driven into the counter
//   ctr_out                     counter Q
//
// Handshake: a client holds req high with a stable operand until its ack.
// The ack is a single cycle and result is valid in that cycle. A req that
// is still high in the cycle after the ack is treated as a fresh request.
module ctr_mode_sched #(
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic [3:0]       load_data,
  output logic             load_ack,
  input  logic             shift_req,
  input  logic [LEN_W-1:0] shift_len,
  output logic             shift_ack,
  input  logic             count_req,
  input  logic [LEN_W-1:0] count_len,
  output logic             count_ack,
  output logic [3:0]       result,
  output logic             busy,
  output logic             ctr_load,
  output logic             ctr_shift,
  output logic             ctr_count,
  output logic [3:0]       ctr_in,
  input  logic [3:0]       ctr_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_GAP    = 3'd2,
    S_SETTLE = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam logic [1:0] C_LOAD  = 2'd0;
  localparam logic [1:0] C_SHIFT = 2'd1;
  localparam logic [1:0] C_COUNT = 2'd2;

  // gap_cnt runs 0..GAP-1
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state, state_nx;
  logic [1:0]       ptr;
  logic [1:0]       op;
  logic [3:0]       data;
  logic [LEN_W-1:0] steps;
  logic [GW-1:0]    gap_cnt;
  logic [3:0]       result_q;

  logic             grant;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic [LEN_W-1:0] win_steps;
  logic [3:0]       req_v;

  function automatic logic [1:0] wrap_inc(input logic [1:0] c);
    return (c == C_COUNT) ? C_LOAD : c + 2'd1;
  endfunction

  // Round-robin search starting at ptr; the spare top bit keeps every
  // 2-bit index in range.
  always_comb begin
    req_v = {1'b0, count_req, shift_req, load_req};
    grant = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!grant && req_v[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
      cand = wrap_inc(cand);
    end
    case (win)
      C_LOAD:  win_steps = LEN_W'(1);
      C_SHIFT: win_steps = shift_len;
      default: win_steps = count_len;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant) state_nx = (win_steps == '0) ? S_ACK : S_PULSE;
      S_PULSE:  state_nx = S_GAP;
      S_GAP:    if (gap_cnt == GW'(GAP - 1))
                  state_nx = (steps != '0) ? S_PULSE : S_SETTLE;
      S_SETTLE: state_nx = S_ACK;
      S_ACK:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= C_LOAD;
      op       <= C_LOAD;
      data     <= '0;
      steps    <= '0;
      gap_cnt  <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (grant) begin
          op    <= win;
          ptr   <= wrap_inc(win);
          data  <= load_data;
          steps <= win_steps;
        end
        S_PULSE: begin
          steps   <= steps - LEN_W'(1);
          gap_cnt <= '0;
        end
        S_GAP:   gap_cnt  <= gap_cnt + GW'(1);
        S_ACK:   result_q <= ctr_out;
        default: ;
      endcase
    end
  end

  // Controls are decoded from registered state only, so they drop the
  // instant reset asserts.
  assign busy      = (state != S_IDLE);
  assign ctr_load  = (state == S_PULSE) && (op == C_LOAD);
  assign ctr_shift = (state == S_PULSE) && (op == C_SHIFT);
  assign ctr_count = (state == S_PULSE) && (op == C_COUNT);
  assign ctr_in    = ctr_load ? data : 4'd0;
  assign load_ack  = (state == S_ACK) && (op == C_LOAD);
  assign shift_ack = (state == S_ACK) && (op == C_SHIFT);
  assign count_ack = (state == S_ACK) && (op == C_COUNT);
  // Q is stable in ACK, so it is passed straight through there and held
  // from the register afterwards.
  assign result    = (state == S_ACK) ? ctr_out : result_q;

endmodule

// File: tb/tb_ctr_mode_sched.sv
module tb_ctr_mode_sched;

  localparam int LEN_W = 4;
  localparam int GAP   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_req, shift_req, count_req;
  logic [3:0]       load_data;
  logic [LEN_W-1:0] shift_len, count_len;
  logic             load_ack, shift_ack, count_ack;
  logic [3:0]       result;
  logic             busy;
  logic             ctr_load, ctr_shift, ctr_count;
  logic [3:0]       ctr_in;
  logic [3:0]       ctr_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  ctr_mode_sched #(.LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .load_data(load_data), .load_ack(load_ack),
    .shift_req(shift_req), .shift_len(shift_len), .shift_ack(shift_ack),
    .count_req(count_req), .count_len(count_len), .count_ack(count_ack),
    .result(result), .busy(busy),
    .ctr_load(ctr_load), .ctr_shift(ctr_shift), .ctr_count(ctr_count),
    .ctr_in(ctr_in), .ctr_out(ctr_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Counter model: J/K stage registers the controls, Q moves one edge later.
  logic       p_load = 1'b0, p_shift = 1'b0, p_count = 1'b0;
  logic [3:0] p_in = 4'd0;
  logic [3:0] q = 4'd0;
  assign ctr_out = q;
  always @(posedge clk) begin
    p_load  <= ctr_load;
    p_shift <= ctr_shift;
    p_count <= ctr_count;
    p_in    <= ctr_in;
    if (p_load)       q <= p_in;
    else if (p_shift) q <= {q[2:0], q[3]};
    else if (p_count) q <= (q >= 4'd9) ? 4'd0 : q + 4'd1;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation for client c (0 load, 1 shift, 2 count). Time t=0 is
  // the window in which req is raised; lat is the window holding the ack.
  task automatic do_op(input int c, input logic [3:0] opnd,
                       output int lat, output int pulses, output int first_t,
                       output logic [3:0] in_seen, output logic [3:0] res,
                       output bit proto_ok);
    bit prev_any;
    bit any;
    bit mine;
    int last_t;
    int n;
    lat = -1; pulses = 0; first_t = -1; in_seen = 4'd0; res = 4'd0;
    proto_ok = 1'b1; prev_any = 1'b0; last_t = -1;
    case (c)
      0: begin load_data = opnd; load_req = 1'b1; end
      1: begin shift_len = opnd; shift_req = 1'b1; end
      default: begin count_len = opnd; count_req = 1'b1; end
    endcase
    for (int t = 1; t <= 100; t++) begin
      step();
      n = int'(ctr_load) + int'(ctr_shift) + int'(ctr_count);
      any = (n != 0);
      mine = (c == 0) ? ctr_load : (c == 1) ? ctr_shift : ctr_count;
      if (n > 1 || (any && prev_any)) proto_ok = 1'b0;
      if (mine) begin
        pulses++;
        if (first_t < 0) first_t = t;
        else if (t - last_t != 1 + GAP) proto_ok = 1'b0;
        last_t = t;
        if (c == 0) in_seen = ctr_in;
      end else if (any) proto_ok = 1'b0;
      if (!ctr_load && ctr_in != 4'd0) proto_ok = 1'b0;
      if ((c != 0 && load_ack) || (c != 1 && shift_ack) || (c != 2 && count_ack))
        proto_ok = 1'b0;
      prev_any = any;
      if ((c == 0 && load_ack) || (c == 1 && shift_ack) || (c == 2 && count_ack)) begin
        lat = t;
        res = result;
        break;
      end
    end
    step();
    load_req = 1'b0; shift_req = 1'b0; count_req = 1'b0;
  endtask

  // Multi-client monitor: records ack order/time/result, drops each req the
  // cycle after its ack (optionally re-raising load once with new data).
  int         ack_client[8];
  int         ack_time[8];
  logic [3:0] ack_res[8];
  int         n_acks;
  bit         multi_ack;

  task automatic run_multi(input int want, input bit relaunch, input logic [3:0] re_data);
    bit dl, ds, dc;
    int k;
    dl = 0; ds = 0; dc = 0; n_acks = 0; multi_ack = 0;
    for (int t = 1; t <= 80; t++) begin
      step();
      if (dl) begin
        if (relaunch) begin load_data = re_data; relaunch = 0; end
        else load_req = 1'b0;
        dl = 0;
      end
      if (ds) begin shift_req = 1'b0; ds = 0; end
      if (dc) begin count_req = 1'b0; dc = 0; end
      k = int'(load_ack) + int'(shift_ack) + int'(count_ack);
      if (k > 1) multi_ack = 1;
      if (k != 0 && n_acks < 8) begin
        ack_client[n_acks] = load_ack ? 0 : shift_ack ? 1 : 2;
        ack_time[n_acks]   = t;
        ack_res[n_acks]    = result;
        n_acks++;
        if (load_ack) dl = 1;
        if (shift_ack) ds = 1;
        if (count_ack) dc = 1;
      end
      if (n_acks >= want) break;
    end
    step();
    load_req = 1'b0; shift_req = 1'b0; count_req = 1'b0;
  endtask

  // tests
  int         lat, pulses, first_t;
  logic [3:0] in_seen, res;
  bit         proto_ok;

  task automatic test_reset();
    bit quiet;
    rst = 1'b1;
    load_req = 0; shift_req = 0; count_req = 0;
    load_data = 0; shift_len = 0; count_len = 0;
    step(); step();
    total_cnt++;
    if ({load_ack, shift_ack, count_ack, busy, ctr_load, ctr_shift, ctr_count, ctr_in, result} !== 15'd0)
      $display("FAIL reset_outputs: got %b expected all zero",
               {load_ack, shift_ack, count_ack, busy, ctr_load, ctr_shift, ctr_count, ctr_in, result});
    else pass_cnt++;
    rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || ctr_load || ctr_shift || ctr_count || load_ack || shift_ack || count_ack) quiet = 0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("FAIL idle_quiet: got activity, expected none for 10 cycles");
    else pass_cnt++;
  endtask

  task automatic test_load();
    do_op(0, 4'd7, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (first_t !== 1 || pulses !== 1) $display("FAIL load_pulse: got first=%0d n=%0d expected first=1 n=1", first_t, pulses);
    else pass_cnt++;
    total_cnt++;
    if (in_seen !== 4'd7) $display("FAIL load_ctr_in: got %0d expected 7", in_seen);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 4 || res !== 4'd7) $display("FAIL load_ack: got lat=%0d res=%0d expected lat=4 res=7", lat, res);
    else pass_cnt++;
    total_cnt++;
    if (proto_ok !== 1'b1) $display("FAIL load_protocol: got violation expected none");
    else pass_cnt++;
    total_cnt++;
    if (result !== 4'd7 || busy !== 1'b0) $display("FAIL load_hold: got result=%0d busy=%b expected 7 0", result, busy);
    else pass_cnt++;
  endtask

  task automatic test_count();
    do_op(2, 4'd5, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (pulses !== 5 || first_t !== 1) $display("FAIL count_pulses: got n=%0d first=%0d expected 5 1", pulses, first_t);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 12 || res !== 4'd2) $display("FAIL count_ack: got lat=%0d res=%0d expected lat=12 res=2", lat, res);
    else pass_cnt++;
    total_cnt++;
    if (proto_ok !== 1'b1) $display("FAIL count_protocol: got violation expected none (spacing 2)");
    else pass_cnt++;
  endtask

  task automatic test_shift();
    do_op(0, 4'b1001, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (res !== 4'b1001) $display("FAIL shift_preload: got %b expected 1001", res);
    else pass_cnt++;
    do_op(1, 4'd1, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (lat !== 4 || res !== 4'b0011 || pulses !== 1 || !proto_ok)
      $display("FAIL shift_len1: got lat=%0d res=%b n=%0d ok=%b expected 4 0011 1 1", lat, res, pulses, proto_ok);
    else pass_cnt++;
    do_op(1, 4'd2, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (lat !== 6 || res !== 4'b1100 || pulses !== 2 || !proto_ok)
      $display("FAIL shift_len2: got lat=%0d res=%b n=%0d ok=%b expected 6 1100 2 1", lat, res, pulses, proto_ok);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    do_op(2, 4'd0, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (lat !== 1 || pulses !== 0 || res !== 4'd12)
      $display("FAIL zero_len: got lat=%0d n=%0d res=%0d expected 1 0 12", lat, pulses, res);
    else pass_cnt++;
    // counter holding 12 (out of mod-10 range) wraps to 0 on count
    do_op(2, 4'd1, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (lat !== 4 || res !== 4'd0) $display("FAIL count_wrap_hi: got lat=%0d res=%0d expected 4 0", lat, res);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; step(); rst = 1'b0;
    load_data = 4'd3; shift_len = 4'd1; count_len = 4'd1;
    load_req = 1'b1; shift_req = 1'b1; count_req = 1'b1;
    run_multi(4, 1'b1, 4'd5);
    total_cnt++;
    if (n_acks !== 4) $display("FAIL b2b_ack_count: got %0d expected 4", n_acks);
    else pass_cnt++;
    if (n_acks == 4) begin
      total_cnt++;
      if (ack_client[0] !== 0 || ack_client[1] !== 1 || ack_client[2] !== 2 || ack_client[3] !== 0)
        $display("FAIL b2b_order: got %0d,%0d,%0d,%0d expected 0,1,2,0",
                 ack_client[0], ack_client[1], ack_client[2], ack_client[3]);
      else pass_cnt++;
      total_cnt++;
      if (ack_time[0] !== 4 || ack_time[1] !== 9 || ack_time[2] !== 14 || ack_time[3] !== 19)
        $display("FAIL b2b_times: got %0d,%0d,%0d,%0d expected 4,9,14,19",
                 ack_time[0], ack_time[1], ack_time[2], ack_time[3]);
      else pass_cnt++;
      total_cnt++;
      if (ack_res[0] !== 4'd3 || ack_res[1] !== 4'd6 || ack_res[2] !== 4'd7 || ack_res[3] !== 4'd5)
        $display("FAIL b2b_results: got %0d,%0d,%0d,%0d expected 3,6,7,5",
                 ack_res[0], ack_res[1], ack_res[2], ack_res[3]);
      else pass_cnt++;
    end
    total_cnt++;
    if (multi_ack !== 1'b0) $display("FAIL b2b_ack_exclusive: got overlapping acks expected none");
    else pass_cnt++;
  endtask

  task automatic test_pointer();
    // last winner was load, so the pointer sits at shift and count beats load
    load_data = 4'd2; count_len = 4'd1;
    load_req = 1'b1; count_req = 1'b1;
    run_multi(2, 1'b0, 4'd0);
    total_cnt++;
    if (n_acks !== 2 || ack_client[0] !== 2 || ack_client[1] !== 0 ||
        ack_time[0] !== 4 || ack_time[1] !== 9 || ack_res[0] !== 4'd6 || ack_res[1] !== 4'd2)
      $display("FAIL pointer_order: got n=%0d c=%0d,%0d t=%0d,%0d r=%0d,%0d expected n=2 c=2,0 t=4,9 r=6,2",
               n_acks, ack_client[0], ack_client[1], ack_time[0], ack_time[1], ack_res[0], ack_res[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    bit saw_ack;
    do_op(0, 4'd5, lat, pulses, first_t, in_seen, res, proto_ok);
    count_len = 4'd9; count_req = 1'b1;
    step(); step(); step();
    total_cnt++;
    if (ctr_count !== 1'b1) $display("FAIL abort_in_pulse: got ctr_count=%b expected 1", ctr_count);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, ctr_load, ctr_shift, ctr_count, ctr_in, load_ack, shift_ack, count_ack, result} !== 15'd0)
      $display("FAIL abort_outputs: got %b expected all zero",
               {busy, ctr_load, ctr_shift, ctr_count, ctr_in, load_ack, shift_ack, count_ack, result});
    else pass_cnt++;
    saw_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (count_ack) saw_ack = 1;
    end
    rst = 1'b0;
    total_cnt++;
    if (saw_ack !== 1'b0) $display("FAIL abort_no_ack: got count_ack during reset expected none");
    else pass_cnt++;
    // the still-pending count is regranted with full latency (Q was 6)
    do_op(2, 4'd9, lat, pulses, first_t, in_seen, res, proto_ok);
    total_cnt++;
    if (lat !== 20 || pulses !== 9 || res !== 4'd5 || !proto_ok)
      $display("FAIL abort_regrant: got lat=%0d n=%0d res=%0d ok=%b expected 20 9 5 1", lat, pulses, res, proto_ok);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_count();
    test_shift();
    test_zero_len();
    test_back_to_back();
    test_pointer();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
